// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between N_REQ requesters.
// One transaction is outstanding at a time; each response is routed back to the requester that issued it.
module xadc_drp_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      drp_den,
    output logic                      drp_dwe,
    output logic [ADDR_W-1:0]         drp_daddr,
    output logic [DATA_W-1:0]         drp_di,
    input  logic [DATA_W-1:0]         drp_do,
    input  logic                      drp_drdy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   win;
    logic               win_found;
    logic               lat_we;
    logic [CNT_W-1:0]   cnt;

    logic [ADDR_W-1:0]  addr_a  [N_REQ];
    logic [DATA_W-1:0]  wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // First valid requester after last_grant, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (!win_found && req_valid[IDX_W'(idx)]) begin
                win       = IDX_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && win_found) ? (ONE_HOT0 << win) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            gnt_idx    <= '0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            drp_daddr  <= '0;
            drp_di     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_idx    <= win;
                        last_grant <= win;
                        lat_we     <= req_we[win];
                        drp_daddr  <= addr_a[win];
                        drp_di     <= wdata_a[win];
                        drp_den    <= 1'b1;
                        drp_dwe    <= req_we[win];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    drp_den <= 1'b0;
                    drp_dwe <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // drdy takes precedence over a coincident timeout
                    if (drp_drdy) begin
                        rsp_data  <= lat_we ? '0 : drp_do;
                        rsp_err   <= 1'b0;
                        rsp_valid <= ONE_HOT0 << gnt_idx;
                        state     <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= ONE_HOT0 << gnt_idx;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
